// File: rtl/text_pkg.sv
// text_pkg: display timing constants and fetch-state type shared by the text scanout blocks.
package text_pkg;
    localparam int H_VISIBLE       = 640;
    localparam int V_VISIBLE       = 480;
    localparam int H_TOTAL         = 800;
    localparam int V_TOTAL         = 525;
    localparam int GLYPH_W         = 8;
    localparam int GLYPH_H         = 16;
    localparam int LINE_PREFETCH_X = 792;

    typedef enum logic [2:0] {
        IDLE,
        CHAR_REQ,
        CHAR_WAIT,
        FONT_REQ,
        FONT_WAIT
    } fetch_state_t;
endpackage

// File: rtl/text_fetch_fsm.sv
// text_fetch_fsm: VRAM then font-ROM fetch sequencer, staged glyph register and sticky underrun flag.
// Build option TEXT_INVERT_EN: code bit 7 inverts the captured glyph row (reverse video).
module text_fetch_fsm
    import text_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        trigger,
    input  logic [11:0] trig_addr,
    input  logic [3:0]  trig_row,
    input  logic        consume,
    output logic        vram_rd,
    output logic [11:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [7:0]  staged_glyph,
    output logic        staged_valid,
    output logic        underrun
);
    fetch_state_t state;
    logic [3:0]   glyph_row;
    logic [7:0]   glyph_in;

`ifdef TEXT_INVERT_EN
    logic invert;
    assign glyph_in = font_data ^ {8{invert}};
`else
    logic unused_code_msb;
    assign unused_code_msb = vram_data[7];
    assign glyph_in = font_data;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            vram_rd      <= 1'b0;
            vram_addr    <= 12'd0;
            font_addr    <= 11'd0;
            glyph_row    <= 4'd0;
            staged_glyph <= 8'h00;
            staged_valid <= 1'b0;
            underrun     <= 1'b0;
`ifdef TEXT_INVERT_EN
            invert       <= 1'b0;
`endif
        end else begin
            vram_rd <= 1'b0;
            if ((trigger && state != IDLE) || (consume && !staged_valid))
                underrun <= 1'b1;
            if (consume)
                staged_valid <= 1'b0;
            // A FONT_WAIT write on a consume edge lands after the consume took the old value.
            case (state)
                IDLE: if (trigger) begin
                    state     <= CHAR_REQ;
                    vram_rd   <= 1'b1;
                    vram_addr <= trig_addr;
                    glyph_row <= trig_row;
                end
                CHAR_REQ: state <= CHAR_WAIT;
                CHAR_WAIT: begin
                    state     <= FONT_REQ;
                    font_addr <= {vram_data[6:0], glyph_row};
`ifdef TEXT_INVERT_EN
                    invert    <= vram_data[7];
`endif
                end
                FONT_REQ: state <= FONT_WAIT;
                FONT_WAIT: begin
                    state        <= IDLE;
                    staged_glyph <= glyph_in;
                    staged_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/text_scanout_ctrl.sv
// text_scanout_ctrl: 80x30 text-mode scanout, prefetching each cell's glyph row one cell ahead of the beam.
// Build option TEXT_INVERT_EN enables reverse video through code bit 7.
module text_scanout_ctrl
    import text_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pix_en,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        vram_rd,
    output logic [11:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        pixel_on,
    output logic        underrun
);
    logic [6:0]  col;
    logic [5:0]  row;
    logic [9:0]  next_y;
    logic        visible;
    logic        cell_start;
    logic        inline_trig;
    logic        line_trig;
    logic        consume;
    logic [11:0] trig_addr;
    logic [3:0]  trig_row;
    logic [7:0]  staged_glyph;
    logic        staged_valid;
    logic [7:0]  shown_glyph;
    logic [7:0]  cur_glyph;

    assign col         = DrawX[9:3];
    assign row         = DrawY[9:4];
    assign visible     = (DrawX < 10'(H_VISIBLE)) && (DrawY < 10'(V_VISIBLE)) && (row < 6'(ROWS));
    assign cell_start  = DrawX[2:0] == 3'd0;
    assign next_y      = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
    assign inline_trig = pix_en && visible && cell_start && (col < 7'(COLS - 1));
    assign line_trig   = pix_en && (DrawX == 10'(LINE_PREFETCH_X)) && (next_y < 10'(V_VISIBLE));
    assign consume     = pix_en && visible && cell_start;
    assign trig_addr   = line_trig ? 12'(next_y[9:4]) * 12'(COLS)
                                   : 12'(row) * 12'(COLS) + 12'(col) + 12'd1;
    assign trig_row    = line_trig ? next_y[3:0] : DrawY[3:0];
    // A missing prefetch shows as a blank cell rather than stale pixels.
    assign shown_glyph = staged_valid ? staged_glyph : 8'h00;

    text_fetch_fsm u_fetch (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .trigger      (inline_trig || line_trig),
        .trig_addr    (trig_addr),
        .trig_row     (trig_row),
        .consume      (consume),
        .vram_rd      (vram_rd),
        .vram_addr    (vram_addr),
        .vram_data    (vram_data),
        .font_addr    (font_addr),
        .font_data    (font_data),
        .staged_glyph (staged_glyph),
        .staged_valid (staged_valid),
        .underrun     (underrun)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur_glyph <= 8'h00;
            pixel_on  <= 1'b0;
        end else if (pix_en) begin
            if (consume)
                cur_glyph <= shown_glyph;
            pixel_on <= !visible ? 1'b0 : cell_start ? shown_glyph[7] : cur_glyph[3'd7 - DrawX[2:0]];
        end
    end
endmodule

// File: tb/tb_text_scanout_ctrl.sv
// tb_text_scanout_ctrl: random VRAM/font contents and line runs checked against a cell/glyph model, plus directed cases.
module tb_text_scanout_ctrl;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        vram_rd;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        pixel_on;
    logic        underrun;

    logic [7:0]  vram [0:4095];
    logic [7:0]  font [0:2047];
    int          total = 0;
    int          bad = 0;
    logic        chk_en = 1'b0;
    logic        exp_pix = 1'b0;
    logic        h_v [0:2];
    logic [11:0] h_a [0:2];
    logic [3:0]  h_r [0:2];
    logic        ob_rd, ob_pix;
    logic [11:0] ob_addr;
    logic [10:0] ob_font;

    text_scanout_ctrl dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .pix_en    (pix_en),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .vram_rd   (vram_rd),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .font_addr (font_addr),
        .font_data (font_data),
        .pixel_on  (pixel_on),
        .underrun  (underrun)
    );

    always #10 Clk = ~Clk;

    // VRAM answers only the cycle after a read strobe; otherwise the bus carries junk.
    always @(posedge Clk) begin
        vram_data <= vram_rd ? vram[vram_addr] : 8'($urandom);
        font_data <= font[font_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] cell_glyph(input int x, input int y);
        logic [7:0] c, g;
        c = vram[(y / 16) * 80 + x / 8];
        g = font[{c[6:0], 4'(y % 16)}];
`ifdef TEXT_INVERT_EN
        if (c[7]) g = ~g;
`endif
        return g;
    endfunction

    function automatic logic model_pix(input int x, input int y);
        logic [7:0] g;
        if (x >= 640 || y >= 480) return 1'b0;
        g = cell_glyph(x, y);
        return g[7 - x % 8];
    endfunction

    function automatic logic model_fetch(input int x, input int y, output logic [11:0] a, output logic [3:0] r);
        int ny;
        ny = (y == 524) ? 0 : y + 1;
        a = 12'd0;
        r = 4'd0;
        if (x == 792 && ny < 480) begin
            a = 12'((ny / 16) * 80);
            r = 4'(ny % 16);
            return 1'b1;
        end
        if (x < 640 && y < 480 && x % 8 == 0 && x / 8 < 79) begin
            a = 12'((y / 16) * 80 + x / 8 + 1);
            r = 4'(y % 16);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic cyc();
        logic        v, pe;
        logic [11:0] a;
        logic [3:0]  r;
        int          px, py;
        @(posedge Clk);
        pe = pix_en;
        px = int'(DrawX);
        py = int'(DrawY);
        v = model_fetch(px, py, a, r) && pe;
        for (int i = 2; i > 0; i--) begin
            h_v[i] = h_v[i-1];
            h_a[i] = h_a[i-1];
            h_r[i] = h_r[i-1];
        end
        h_v[0] = v;
        h_a[0] = a;
        h_r[0] = r;
        if (pe) exp_pix = model_pix(px, py);
        @(negedge Clk);
        if (chk_en) begin
            check("pixel_on", pixel_on, exp_pix);
            check("vram_rd", vram_rd, h_v[0]);
            if (h_v[0]) check("vram_addr", vram_addr, h_a[0]);
            if (h_v[2]) check("font_addr", font_addr, {vram[h_a[2]][6:0], h_r[2]});
            check("underrun", underrun, 0);
        end
    endtask

    task automatic clear_model();
        exp_pix = 1'b0;
        for (int i = 0; i < 3; i++) h_v[i] = 1'b0;
    endtask

    task automatic do_reset();
        pix_en = 1'b0;
        Reset_n = 1'b0;
        clear_model();
        cyc();
        cyc();
        Reset_n = 1'b1;
        cyc();
    endtask

    task automatic pix(input int x, input int y);
        pix_en = 1'b1;
        DrawX = 10'(x);
        DrawY = 10'(y);
        cyc();
        ob_rd = vram_rd;
        ob_addr = vram_addr;
        ob_pix = pixel_on;
        ob_font = font_addr;
        if (x == 8 && y == 16) begin
            check("row16_rd", ob_rd, 1);
            check("row16_addr", ob_addr, 82);
        end
        if (x == 9 && y == 16) check("row16_glyph_row", ob_font[3:0], 0);
        if (x == 624 && y == 479) check("last_cell_addr", ob_addr, 2399);
        if (x == 625 && y == 479) check("last_glyph_row", ob_font[3:0], 15);
        if (x == 792 && y >= 480 && y <= 523) check("vblank_no_fetch", ob_rd, 0);
        pix_en = 1'b0;
        cyc();
    endtask

    task automatic seg(input int l);
        int p;
        p = (l == 0) ? 524 : l - 1;
        for (int x = 784; x < 800; x++) pix(x, p);
        for (int x = 0; x < 800; x++) pix(x, l);
    endtask

    task automatic glyph_case(input logic [7:0] code, input logic [7:0] want);
        vram[0] = code;
        font[11'h410] = 8'h18;
        do_reset();
        for (int x = 784; x < 800; x++) begin
            pix(x, 524);
            if (x == 792) begin
                check("line_start_rd", ob_rd, 1);
                check("line_start_addr", ob_addr, 0);
            end
            if (x == 793) check("line_start_font_addr", ob_font, 11'h410);
        end
        for (int x = 0; x < 800; x++) begin
            pix(x, 0);
            if (x < 8) check("glyph_pixel", ob_pix, want[7-x]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
        clear_model();
        do_reset();
        check("reset_vram_rd", vram_rd, 0);
        check("reset_vram_addr", vram_addr, 0);
        check("reset_font_addr", font_addr, 0);
        check("reset_pixel_on", pixel_on, 0);
        check("reset_underrun", underrun, 0);

        chk_en = 1'b1;
        glyph_case(8'h41, 8'h18);
`ifdef TEXT_INVERT_EN
        glyph_case(8'hC1, 8'hE7);
`else
        glyph_case(8'hC1, 8'h18);
`endif
        seg(16);
        seg(479);
        seg(480);
        seg(524);
        for (int n = 0; n < 12; n++) seg(int'($urandom_range(0, 524)));

        // Back-to-back pixel strobes keep the fetcher busy when the next cell is due.
        chk_en = 1'b0;
        vram[161] = 8'h41;
        font[11'h412] = 8'hFF;
        do_reset();
        pix_en = 1'b1;
        DrawX = 10'd0;
        DrawY = 10'd32;
        cyc();
        DrawX = 10'd8;
        cyc();
        check("underrun_set", underrun, 1);
        pix_en = 1'b0;
        cyc();
        for (int x = 9; x < 16; x++) begin
            pix(x, 32);
            check("underrun_blank_px", ob_pix, 0);
            check("underrun_sticky", underrun, 1);
        end
        repeat (20) cyc();
        check("underrun_still_set", underrun, 1);
        do_reset();
        check("underrun_cleared", underrun, 0);

        chk_en = 1'b1;
        pix_en = 1'b1;
        DrawX = 10'd792;
        DrawY = 10'd15;
        cyc();
        pix_en = 1'b0;
        cyc();
        check("midfetch_addr_live", vram_addr, 80);
        Reset_n = 1'b0;
        #1;
        check("midfetch_rst_rd", vram_rd, 0);
        check("midfetch_rst_addr", vram_addr, 0);
        check("midfetch_rst_font", font_addr, 0);
        check("midfetch_rst_pix", pixel_on, 0);
        check("midfetch_rst_und", underrun, 0);
        clear_model();
        cyc();
        cyc();
        Reset_n = 1'b1;
        cyc();
        seg(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/text_scanout_ctrl.md
# text_scanout_ctrl

Text-mode scanout controller for the VGA path. It turns the 640x480 display into an 80x30 grid of 8x16 glyph cells. It runs one cell ahead of the beam: it reads each cell's character code from the text VRAM, then reads that glyph's current row from the 128-glyph font ROM. It serialises the row into a per-pixel `pixel_on` that the color mapper turns into foreground/background RGB.

## Interface
- `COLS`, 80: text columns per line
- `ROWS`, 30: text rows per frame
- `Clk`  in  1  system clock, 50 MHz
- `Reset_n`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  one-Clk strobe per pixel (every other Clk); `DrawX`/`DrawY` are valid and advance after it
- `DrawX`  in  10  current pixel column, 0..799
- `DrawY`  in  10  current pixel line, 0..524
- `vram_rd`  out  1  VRAM read strobe, one Clk wide
- `vram_addr`  out  12  cell index, row*COLS+col, 0..2399
- `vram_data`  in  8  character code, valid exactly 1 Clk after `vram_rd`
- `font_addr`  out  11  {code[6:0], glyph_row[3:0]}
- `font_data`  in  8  glyph row, MSB = leftmost pixel, valid 1 Clk after `font_addr` is presented
- `pixel_on`  out  1  glyph bit for the most recent `pix_en` pixel
- `underrun`  out  1  sticky; set when a cell was needed before its prefetch finished

## Operation
- Visible area: `DrawX < 640` and `DrawY < 480`.
- Cell coordinates: `col = DrawX[9:3]`, `row = DrawY[9:4]`, `glyph_row = DrawY[3:0]`.
- Prefetch triggers, each sampled on a `pix_en` edge:
  - In-line: visible, `DrawX[2:0] == 0`, `col < COLS-1`. Fetches cell (`row`, `col+1`).
  - Line-start: `DrawX == 792`. Next line is `(DrawY == 524) ? 0 : DrawY+1`; fetch fires only if next line < 480. Fetches cell (next_row, 0) with next_glyph_row.
- Fetch FSM states:
  - `IDLE`: goes to `CHAR_REQ` on a trigger; latches the target address and glyph_row.
  - `CHAR_REQ`: `vram_rd = 1`, `vram_addr` driven. Next state `CHAR_WAIT`.
  - `CHAR_WAIT`: captures `vram_data`. Next state `FONT_REQ`.
  - `FONT_REQ`: `font_addr` driven from the captured code and glyph_row. Next state `FONT_WAIT`.
  - `FONT_WAIT`: writes `font_data` into the staged-glyph register and sets `staged_valid`. Next state `IDLE`.
- Consumption: on a visible `pix_en` edge with `DrawX[2:0] == 0`:
  - Staged glyph moves into the current-glyph register; `staged_valid` clears.
  - If `staged_valid` was 0, use glyph 0x00 and set `underrun`.
- Trigger arriving while FSM is not `IDLE`: ignored, and `underrun` is set.
- Consume and FONT_WAIT write on the same edge: the consume takes the old staged value, and the write then sets `staged_valid`.
- `pixel_on`:
  - Updated only on `pix_en` edges.
  - Visible: equals bit `7 - DrawX[2:0]` of the current cell's glyph. At `DrawX[2:0] == 0` the staged glyph is bypassed so there is no gap.
  - Non-visible: 0.
- Arithmetic: `vram_addr` is computed 12 bits wide. Row 29, col 79 gives 2399; no wrap is possible inside the visible area.

## Timing
- Reset values: `vram_rd` 0, `vram_addr` 0, `font_addr` 0, `pixel_on` 0, `underrun` 0, FSM `IDLE`, `staged_valid` 0.
- Deasserting `Reset_n` mid-fetch abandons the fetch; the next trigger restarts cleanly.
- Fetch latency: `vram_rd` 1 Clk after the trigger edge; staged glyph valid 4 Clk after the trigger edge.
- Slack: a cell lasts 16 Clk, so a fetch has 11 Clk of slack.
- `pixel_on` latency: 1 Clk after the `pix_en` edge that sampled `DrawX`.

## Configuration
- `TEXT_INVERT_EN` defined:
  - Code bit 7 selects reverse video; the glyph row is bitwise inverted on capture.
  - `font_addr` still uses `code[6:0]`.
- `TEXT_INVERT_EN` undefined:
  - Code bit 7 is ignored and no inversion logic is built.

## Structure
- Package `text_pkg`:
  - Constants: `H_VISIBLE = 640`, `V_VISIBLE = 480`, `H_TOTAL = 800`, `V_TOTAL = 525`, `GLYPH_W = 8`, `GLYPH_H = 16`, `LINE_PREFETCH_X = 792`.
  - Typedef: `fetch_state_t` enum (`IDLE`, `CHAR_REQ`, `CHAR_WAIT`, `FONT_REQ`, `FONT_WAIT`).
- Sub-module `text_fetch_fsm`: owns the FSM, staged-glyph register and `underrun` logic.
- Top level keeps trigger decode, the current-glyph register and `pixel_on`.

## Test plan
- Line-start fetch + pixel serialisation:
  - Stimulus: VRAM[0] = 0x41, font[0x410] = 0x18; run line 524 → line 0.
  - Expected: `vram_addr` = 0 with `vram_rd` after `DrawX == 792`; `font_addr` = 0x410.
  - Expected: `pixel_on` for `DrawX` 0..7 = 0,0,0,1,1,0,0,0.
- Row addressing: `DrawY` = 16, `DrawX` = 8 → `vram_addr` = 82, glyph_row 0. `DrawY` = 479, `DrawX` = 624 → `vram_addr` = 2399, glyph_row 15.
- Blanking:
  - `DrawX` 640..799 → `pixel_on` = 0, and only the fetch at 792 occurs.
  - `DrawY` = 480..523 at `DrawX` = 792 → no fetch.
  - `DrawY` = 524 at `DrawX` = 792 → fetch for line 0.
- Reverse video: VRAM code 0xC1, font[0x410] = 0x18:
  - With `TEXT_INVERT_EN`: pixels 1,1,1,0,0,1,1,1.
  - Without: 0,0,0,1,1,0,0,0.
- Underrun: hold the FSM off `IDLE` by forcing back-to-back triggers from the bench → glyph 0x00 shown and `underrun` = 1 until reset.
- Reset mid-fetch: drop `Reset_n` during `CHAR_WAIT` → all outputs 0 immediately; the next line-start fetch completes normally.
